// File: rtl/mole_game_core.sv
// Whack-a-mole game core: pseudo-random mole placement, shrinking display interval, hit/miss scoring.
// Latency: every output is registered; an input sampled at edge N is reflected right after edge N.
// No backpressure: single-cycle pulse inputs are consumed on the edge they are sampled.
module mole_game_core #(
  parameter int          NUM_HOLES  = 8,
  parameter int          POS_W      = 3,
  parameter int          MOLE_TICKS = 50000000,
  parameter int          MIN_TICKS  = 12500000,
  parameter int          SCORE_W    = 8,
  parameter int          MAX_MISSES = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 guess_now,
  input  logic [POS_W-1:0]     user_guess,
  output logic [POS_W-1:0]     mole_pos,
  output logic                 mole_change,
  output logic                 guess_correct,
  output logic                 guess_wrong,
  output logic                 mole_timeout,
  output logic [SCORE_W-1:0]   score,
  output logic [3:0]           misses,
  output logic                 game_over,
  output logic [NUM_HOLES-1:0] led
);

  localparam int TW = $clog2(MOLE_TICKS + 1);

  localparam logic [POS_W-1:0]   LAST_HOLE = POS_W'(NUM_HOLES - 1);
  localparam logic [POS_W-1:0]   HOLES     = POS_W'(NUM_HOLES);
  localparam logic [TW-1:0]      INIT_IV   = TW'(MOLE_TICKS);
  localparam logic [TW-1:0]      MIN_IV    = TW'(MIN_TICKS);
  localparam logic [3:0]         MISS_END  = 4'(MAX_MISSES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [NUM_HOLES-1:0] LED_ONE = {{(NUM_HOLES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SHOW, OVER} state_t;

  state_t            state;
  logic [15:0]       lfsr;
  logic [TW-1:0]     interval;
  logic [TW-1:0]     timer;
  logic [POS_W-1:0]  cand;
  logic [POS_W-1:0]  new_pos;
  logic [TW-1:0]     diff;
  logic [TW-1:0]     shrunk;
  logic [3:0]        miss_inc;
  logic              lfsr_fb;

  // Next mole position: fold the LFSR sample into range, then step off the current hole.
  always_comb begin
    cand = lfsr[POS_W-1:0];
    if (cand > LAST_HOLE) cand = cand - HOLES;
    new_pos = cand;
    if (cand == mole_pos) new_pos = (mole_pos == LAST_HOLE) ? '0 : mole_pos + POS_W'(1);
  end

  // Interval after a hit: lose one eighth, never below the floor; also the incremented miss count.
  always_comb begin
    diff     = interval - (interval >> 3);
    shrunk   = (diff < MIN_IV) ? MIN_IV : diff;
    miss_inc = misses + 4'd1;
    lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  end

  // Game FSM with all outputs registered; pulses default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lfsr          <= LFSR_SEED;
      interval      <= INIT_IV;
      timer         <= '0;
      mole_pos      <= '0;
      mole_change   <= 1'b0;
      guess_correct <= 1'b0;
      guess_wrong   <= 1'b0;
      mole_timeout  <= 1'b0;
      score         <= '0;
      misses        <= '0;
      game_over     <= 1'b0;
      led           <= '0;
    end else begin
      lfsr          <= {lfsr[14:0], lfsr_fb};
      mole_change   <= 1'b0;
      guess_correct <= 1'b0;
      guess_wrong   <= 1'b0;
      mole_timeout  <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state       <= SHOW;
            mole_pos    <= new_pos;
            mole_change <= 1'b1;
            score       <= '0;
            misses      <= '0;
            interval    <= INIT_IV;
            timer       <= '0;
            game_over   <= 1'b0;
            led         <= LED_ONE << new_pos;
          end
        end
        SHOW: begin
          if (guess_now && (user_guess == mole_pos)) begin
            guess_correct <= 1'b1;
            if (score != SCORE_MAX) score <= score + SCORE_W'(1);
            mole_pos    <= new_pos;
            mole_change <= 1'b1;
            timer       <= '0;
            interval    <= shrunk;
            led         <= LED_ONE << new_pos;
          end else if (guess_now) begin
            guess_wrong <= 1'b1;
            misses      <= miss_inc;
            if (miss_inc == MISS_END) begin
              state     <= OVER;
              game_over <= 1'b1;
              led       <= '1;
            end else begin
              timer <= timer + TW'(1);
            end
          end else if (timer >= interval - TW'(1)) begin
            // >= rather than == so a wrong guess landing on the expiry cycle only delays the timeout.
            mole_timeout <= 1'b1;
            misses       <= miss_inc;
            if (miss_inc == MISS_END) begin
              state     <= OVER;
              game_over <= 1'b1;
              led       <= '1;
            end else begin
              mole_pos    <= new_pos;
              mole_change <= 1'b1;
              timer       <= '0;
              led         <= LED_ONE << new_pos;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_game_core.sv
// Randomized scoreboard bench for mole_game_core (6 holes, 4-bit score, short intervals).
// A reference model predicts every cycle's outputs into a queue; a monitor pops and compares.
// Also checks mole range / no-repeat properties and immediate asynchronous reset.
module tb_mole_game_core;
  localparam int NH = 6;
  localparam int PW = 3;
  localparam int MT = 20;
  localparam int MN = 8;
  localparam int SW = 4;
  localparam int MM = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct packed {
    logic [PW-1:0] pos;
    logic          chg;
    logic          cor;
    logic          wr;
    logic          to;
    logic [SW-1:0] sc;
    logic [3:0]    mi;
    logic          go;
    logic [NH-1:0] led;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst, start, guess_now;
  logic [PW-1:0] user_guess;
  logic [PW-1:0] mole_pos;
  logic          mole_change, guess_correct, guess_wrong, mole_timeout, game_over;
  logic [SW-1:0] score;
  logic [3:0]    misses;
  logic [NH-1:0] led;

  mole_game_core #(
    .NUM_HOLES(NH), .POS_W(PW), .MOLE_TICKS(MT), .MIN_TICKS(MN),
    .SCORE_W(SW), .MAX_MISSES(MM), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .guess_now(guess_now), .user_guess(user_guess),
    .mole_pos(mole_pos), .mole_change(mole_change), .guess_correct(guess_correct),
    .guess_wrong(guess_wrong), .mole_timeout(mole_timeout), .score(score),
    .misses(misses), .game_over(game_over), .led(led)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  obs_t expq[$];

  // Reference model: mode 0 idle, 1 playing, 2 game over.
  int          m_mode, m_score, m_miss, m_iv, m_el;
  logic [PW-1:0] m_mole;
  logic [15:0] m_lfsr;

  function automatic obs_t dut_obs();
    obs_t o;
    o.pos = mole_pos; o.chg = mole_change; o.cor = guess_correct; o.wr = guess_wrong;
    o.to = mole_timeout; o.sc = score; o.mi = misses; o.go = game_over; o.led = led;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pick(input logic [15:0] l, input logic [PW-1:0] prev);
    int c;
    c = int'(l[PW-1:0]);
    if (c >= NH) c = c - NH;
    if (c == int'(prev)) c = (int'(prev) + 1) % NH;
    return PW'(c);
  endfunction

  task automatic model_step(input bit r, input bit s, input bit g, input logic [PW-1:0] u);
    obs_t e;
    logic [PW-1:0] np;
    e = '0;
    if (r) begin
      m_mode = 0; m_mole = '0; m_score = 0; m_miss = 0; m_iv = MT; m_el = 0; m_lfsr = SEED;
    end else begin
      np = pick(m_lfsr, m_mole);
      if (m_mode != 1) begin
        if (s) begin
          m_mole = np; e.chg = 1'b1; m_score = 0; m_miss = 0; m_iv = MT; m_el = 0; m_mode = 1;
        end
      end else if (g && u == m_mole) begin
        e.cor = 1'b1;
        if (m_score < (1 << SW) - 1) m_score++;
        m_mole = np; e.chg = 1'b1; m_el = 0;
        m_iv = m_iv - m_iv / 8;
        if (m_iv < MN) m_iv = MN;
      end else if (g) begin
        e.wr = 1'b1; m_miss++;
        if (m_miss == MM) m_mode = 2; else m_el++;
      end else if (m_el >= m_iv - 1) begin
        e.to = 1'b1; m_miss++;
        if (m_miss == MM) m_mode = 2;
        else begin m_mole = np; e.chg = 1'b1; m_el = 0; end
      end else begin
        m_el++;
      end
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    e.pos = m_mole; e.sc = SW'(m_score); e.mi = 4'(m_miss); e.go = (m_mode == 2);
    e.led = (m_mode == 0) ? '0 : (m_mode == 2) ? '1 : NH'(1 << m_mole);
    expq.push_back(e);
  endtask

  task automatic tick(input bit r, input bit s, input bit g, input logic [PW-1:0] u);
    @(negedge clk);
    rst = r; start = s; guess_now = g; user_guess = u;
    if (r) begin
      #1;
      chk("async_rst", 32'(dut_obs()), 32'(obs_t'('0)));
    end
    model_step(r, s, g, u);
  endtask

  // Monitor: one expected entry per clock edge, plus model-independent mole properties.
  logic [PW-1:0] prev_pos = '0;
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = dut_obs();
        chk("outputs", 32'(a), 32'(e));
        chk("pos_range", 32'(a.pos < NH), 32'd1);
        if (a.chg && !rst) chk("no_repeat", 32'(a.pos != prev_pos), 32'd1);
        prev_pos = a.pos;
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; guess_now = 1'b0; user_guess = '0;
    m_mode = 0; m_mole = '0; m_score = 0; m_miss = 0; m_iv = MT; m_el = 0; m_lfsr = SEED;
    repeat (3) tick(1, 0, 0, 0);
    // Guesses while idle are ignored.
    for (int i = 0; i < 4; i++) tick(0, 0, 1'($urandom % 2), PW'($urandom % 8));
    // First game: one timeout, then 16 hits to saturate the score and floor the interval.
    tick(0, 1, 0, 0);
    repeat (25) tick(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      repeat (2) tick(0, 0, 0, 0);
      tick(0, 0, 1, m_mole);
    end
    // Out-of-range guess and off-by-one guess are both wrong; third miss ends the game.
    tick(0, 0, 1, PW'(6));
    repeat (3) tick(0, 0, 0, 0);
    tick(0, 0, 1, PW'((int'(m_mole) + 1) % NH));
    repeat (3) tick(0, 0, 1, m_mole);
    tick(0, 1, 0, 0);
    // Unattended game: three timeouts at the initial interval, then over.
    repeat (70) tick(0, 0, 0, 0);
    tick(0, 0, 1, m_mole);
    // Mid-game asynchronous reset after a few hits.
    tick(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0);
      tick(0, 0, 1, m_mole);
    end
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    // Randomized play.
    for (int i = 0; i < 8000; i++) begin
      bit r, s, g;
      logic [PW-1:0] u;
      r = ($urandom_range(0, 999) < 2);
      s = ($urandom % 40) == 0;
      g = ($urandom % 4) == 0;
      u = ($urandom % 3 != 0) ? m_mole : PW'($urandom % 8);
      tick(r, s, g, u);
    end
    @(posedge clk);
    #3;
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
